// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: fetch-stage bus between if_fetch_unit and the rest of the pipeline
// Ports (slave = fetch unit side):
//   le, br_taken, br_target, imem_data        -> into fetch unit
//   imem_addr, if_instr, if_pc, if_npc,
//   if_valid, redirect_pend                    <- out of fetch unit
//   fetch_count                                <- only with IF_FETCH_COUNT_EN
interface if_fetch_unit_if #(parameter int IMEM_AW = 9);
  logic               le;
  logic               br_taken;
  logic [31:0]        br_target;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic [31:0]        if_instr;
  logic [31:0]        if_pc;
  logic [31:0]        if_npc;
  logic               if_valid;
  logic               redirect_pend;
`ifdef IF_FETCH_COUNT_EN
  logic [31:0]        fetch_count;
  modport slave  (input le, br_taken, br_target, imem_data,
                  output imem_addr, if_instr, if_pc, if_npc, if_valid, redirect_pend, fetch_count);
  modport master (output le, br_taken, br_target, imem_data,
                  input imem_addr, if_instr, if_pc, if_npc, if_valid, redirect_pend, fetch_count);
`else
  modport slave  (input le, br_taken, br_target, imem_data,
                  output imem_addr, if_instr, if_pc, if_npc, if_valid, redirect_pend);
  modport master (output le, br_taken, br_target, imem_data,
                  input imem_addr, if_instr, if_pc, if_npc, if_valid, redirect_pend);
`endif
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage holding PC/nPC with delay-slot redirect and stall-time redirect latching
// Ports: clk, rst (async, active-high), bus (if_fetch_unit_if.slave).
// Optional macro IF_FETCH_COUNT_EN adds bus.fetch_count, counting advancing cycles.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 9
) (
  input logic            clk,
  input logic            rst,
  if_fetch_unit_if.slave bus
);
  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;
  state_t      state, state_nx;
  logic [31:0] pc, npc, pend_tgt, pc_nx, npc_nx, pend_nx, tgt;
  logic        adv;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      npc      <= RESET_PC + 32'd4;
      pend_tgt <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      npc      <= npc_nx;
      pend_tgt <= pend_nx;
    end
  // A live redirect always beats a latched one; the latched target is consumed on the advance out of PEND.
  always_comb begin
    tgt      = bus.br_target & ~32'h3;
    adv      = (state != BOOT) && bus.le;
    state_nx = state == BOOT ? RUN :
               bus.le        ? RUN :
               (state == PEND || bus.br_taken) ? PEND : RUN;
    pc_nx    = adv ? npc : pc;
    npc_nx   = !adv         ? npc :
               bus.br_taken ? tgt :
               state == PEND ? pend_tgt : npc + 32'd4;
    pend_nx  = (state != BOOT && !bus.le && bus.br_taken) ? tgt : pend_tgt;
  end
  assign bus.if_valid      = state != BOOT;
  assign bus.if_instr      = bus.if_valid ? bus.imem_data : 32'h0;
  assign bus.if_pc         = pc;
  assign bus.if_npc        = npc;
  assign bus.imem_addr     = pc[IMEM_AW-1:0];
  assign bus.redirect_pend = state == PEND;
`ifdef IF_FETCH_COUNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (adv) cnt <= cnt + 32'd1;
  assign bus.fetch_count = cnt;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed plus randomized checks of if_fetch_unit against a fetch-stream model
module tb_if_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int   vecs = 0, errs = 0;
  logic [31:0] mem [128];
  if_fetch_unit_if #(.IMEM_AW(9)) bus ();
  if_fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(9)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_data = mem[7'(bus.imem_addr >> 2)];
  bit          m_boot, m_pend;
  logic [31:0] m_pc, m_npc, m_tgt, m_cnt;
  task automatic m_reset();
    m_boot = 1; m_pend = 0; m_pc = 32'h0; m_npc = 32'h4; m_tgt = 32'h0; m_cnt = 0;
  endtask
  task automatic m_edge(input bit le, input bit br, input logic [31:0] t);
    logic [31:0] a;
    a = {t[31:2], 2'b00};
    if (m_boot) m_boot = 0;
    else if (le) begin
      m_cnt++;
      m_pc  = m_npc;
      m_npc = br ? a : m_pend ? m_tgt : m_npc + 32'd4;
      m_pend = 0;
    end else if (br) begin
      m_pend = 1;
      m_tgt  = a;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_all();
    chk("valid", 32'(bus.if_valid), 32'(!m_boot));
    chk("instr", bus.if_instr, m_boot ? 32'h0 : mem[m_pc[8:2]]);
    chk("pc", bus.if_pc, m_pc);
    chk("npc", bus.if_npc, m_npc);
    chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc[8:0]));
    chk("pend", 32'(bus.redirect_pend), 32'(m_pend));
`ifdef IF_FETCH_COUNT_EN
    chk("count", bus.fetch_count, m_cnt);
`endif
  endtask
  task automatic step(input bit le, input bit br, input logic [31:0] t);
    bus.le = le; bus.br_taken = br; bus.br_target = t;
    @(posedge clk);
    m_edge(le, br, t);
    #1;
    chk_all();
  endtask
  initial begin
    logic [31:0] held;
    foreach (mem[i]) mem[i] = $urandom;
    mem[0] = 32'h2401_0005;
    rst = 1; bus.le = 1; bus.br_taken = 0; bus.br_target = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_all();
    chk("c0_valid", 32'(bus.if_valid), 32'h0);
    chk("c0_instr", bus.if_instr, 32'h0);
    step(1, 1, 32'h200);
    chk("c1_pc", bus.if_pc, 32'h0);
    chk("c1_instr", bus.if_instr, 32'h2401_0005);
    step(1, 0, 0); chk("seq4", bus.if_pc, 32'h4);
    step(1, 0, 0); chk("seq8", bus.if_pc, 32'h8);
    step(1, 1, 32'h40); chk("slot12", bus.if_pc, 32'hC);
    step(1, 0, 0); chk("tgt40", bus.if_pc, 32'h40);
    step(1, 0, 0); chk("tgt44", bus.if_pc, 32'h44);
    step(1, 1, 32'h10); step(1, 0, 0); chk("at16", bus.if_pc, 32'h10);
    held = bus.if_instr;
    repeat (3) begin step(0, 0, 0); chk("stall_pc", bus.if_pc, 32'h10); chk("stall_instr", bus.if_instr, held); end
    step(1, 0, 0); chk("after_stall", bus.if_pc, 32'h14);
    step(1, 1, 32'h10); step(1, 0, 0);
    step(0, 1, 32'h80); chk("pend_set", 32'(bus.redirect_pend), 32'h1);
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0); chk("pend_slot", bus.if_pc, 32'h14); chk("pend_clr", 32'(bus.redirect_pend), 32'h0);
    step(1, 0, 0); chk("pend_tgt", bus.if_pc, 32'h80);
    step(1, 1, 32'h10); step(1, 0, 0);
    step(0, 1, 32'h80); step(0, 1, 32'hC0);
    step(1, 0, 0); step(1, 0, 0); chk("latest_wins", bus.if_pc, 32'hC0);
    step(1, 1, 32'h43); step(1, 0, 0); chk("misalign", bus.if_pc, 32'h40);
    step(1, 1, 32'hFFFF_FFFC); step(1, 0, 0); chk("wrap_hi", bus.if_pc, 32'hFFFF_FFFC);
    step(1, 0, 0); chk("wrap_lo", bus.if_pc, 32'h0);
    step(0, 1, 32'h100); chk("pre_rst_pend", 32'(bus.redirect_pend), 32'h1);
    #2 rst = 1;
    #1 m_reset();
    chk_all();
    chk("arst_pc", bus.if_pc, 32'h0);
    chk("arst_npc", bus.if_npc, 32'h4);
    @(negedge clk) rst = 0;
    step(1, 0, 0);
`ifdef IF_FETCH_COUNT_EN
    repeat (10) step(1, 0, 0);
    chk("count10", bus.fetch_count, 32'd10);
    @(negedge clk) rst = 1;
    #1 m_reset();
    chk("count_rst", bus.fetch_count, 32'd0);
    @(negedge clk) rst = 0;
    step(1, 0, 0);
`endif
    repeat (400) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(0, 511)));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
